// File: rtl/opll_slot_sequencer.sv
// Slot/stage timing generator for the OPLL core: main slot/stage counter, lagged tap copies,
// sticky resync request, frame-start decode and frame counter.
module opll_slot_sequencer #(
  parameter int unsigned NUM_SLOTS  = 18,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DELAY      = 0,
  parameter int unsigned NUM_TAPS   = 2,
  parameter int unsigned TAP_LAG    = 1,
  parameter int unsigned FRAME_W    = 8,
  localparam int unsigned TOTAL     = NUM_SLOTS * NUM_STAGES,
  localparam int unsigned SLOT_W    = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned STAGE_W   = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clkena,
  input  logic                         sync_req,
  output logic [SLOT_W-1:0]            slot,
  output logic [STAGE_W-1:0]           stage,
  output logic [NUM_TAPS*SLOT_W-1:0]   tap_slot,
  output logic [NUM_TAPS*STAGE_W-1:0]  tap_stage,
  output logic                         frame_start,
  output logic [FRAME_W-1:0]           frame_count,
  output logic                         sync_pending
);

  // Position of tap k relative to a main position, wrapped into 0..TOTAL-1.
  function automatic int unsigned tap_pos(input int unsigned main_pos, input int unsigned k);
    int unsigned lag;
    lag = ((k + 1) * TAP_LAG) % TOTAL;
    return (main_pos + TOTAL - lag) % TOTAL;
  endfunction

  localparam int unsigned RESET_POS = TOTAL - 1 - DELAY;

  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [SLOT_W-1:0]  tap_slot_q  [NUM_TAPS];
  logic [SLOT_W-1:0]  tap_slot_d  [NUM_TAPS];
  logic [STAGE_W-1:0] tap_stage_q [NUM_TAPS];
  logic [STAGE_W-1:0] tap_stage_d [NUM_TAPS];
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pending_q, pending_d;
  logic               load;
  logic               stage_wrap;
  logic               natural_wrap;

  // Next-state: sync load replaces the increment; wrap compares use >= so stray values recover.
  always_comb begin
    load         = clkena & (sync_req | pending_q);
    stage_wrap   = (stage_q >= STAGE_W'(NUM_STAGES - 1));
    natural_wrap = stage_wrap && (slot_q >= SLOT_W'(NUM_SLOTS - 1));

    slot_d    = slot_q;
    stage_d   = stage_q;
    frame_d   = frame_q;
    pending_d = pending_q;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_slot_d[k]  = tap_slot_q[k];
      tap_stage_d[k] = tap_stage_q[k];
    end

    if (load) begin
      slot_d    = '0;
      stage_d   = '0;
      pending_d = 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_slot_d[k]  = SLOT_W'(tap_pos(0, k) / NUM_STAGES);
        tap_stage_d[k] = STAGE_W'(tap_pos(0, k) % NUM_STAGES);
      end
    end else begin
      if (sync_req) begin
        pending_d = 1'b1;
      end
      if (clkena) begin
        if (stage_wrap) begin
          stage_d = '0;
          slot_d  = (slot_q >= SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
        if (natural_wrap) begin
          frame_d = frame_q + FRAME_W'(1);
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
          if (tap_stage_q[k] >= STAGE_W'(NUM_STAGES - 1)) begin
            tap_stage_d[k] = '0;
            tap_slot_d[k]  = (tap_slot_q[k] >= SLOT_W'(NUM_SLOTS - 1)) ? '0
                                                                         : tap_slot_q[k] + SLOT_W'(1);
          end else begin
            tap_stage_d[k] = tap_stage_q[k] + STAGE_W'(1);
          end
        end
      end
    end
  end

  // State registers; reset places main DELAY positions before the last one of the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= SLOT_W'(RESET_POS / NUM_STAGES);
      stage_q   <= STAGE_W'(RESET_POS % NUM_STAGES);
      frame_q   <= '0;
      pending_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_slot_q[k]  <= SLOT_W'(tap_pos(RESET_POS, k) / NUM_STAGES);
        tap_stage_q[k] <= STAGE_W'(tap_pos(RESET_POS, k) % NUM_STAGES);
      end
    end else begin
      slot_q    <= slot_d;
      stage_q   <= stage_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_slot_q[k]  <= tap_slot_d[k];
        tap_stage_q[k] <= tap_stage_d[k];
      end
    end
  end

  // Output packing and frame-start decode of the registered main position.
  always_comb begin
    slot         = slot_q;
    stage        = stage_q;
    frame_count  = frame_q;
    sync_pending = pending_q;
    frame_start  = (slot_q == '0) && (stage_q == '0);
    tap_slot     = '0;
    tap_stage    = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_slot[k*SLOT_W +: SLOT_W]    = tap_slot_q[k];
      tap_stage[k*STAGE_W +: STAGE_W] = tap_stage_q[k];
    end
  end

endmodule

// File: tb/tb_opll_slot_sequencer.sv
// Directed bench: default, DELAY=5 and 5x3-slot configurations sharing one clock.
module tb_opll_slot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default configuration
  logic       a_rst_n, a_en, a_sync;
  logic [4:0] a_slot;
  logic [1:0] a_stage;
  logic [9:0] a_tap_slot;
  logic [3:0] a_tap_stage;
  logic       a_fs, a_pend;
  logic [7:0] a_fc;

  // DELAY=5
  logic       d_rst_n, d_en, d_sync;
  logic [4:0] d_slot;
  logic [1:0] d_stage;
  logic [9:0] d_tap_slot;
  logic [3:0] d_tap_stage;
  logic       d_fs, d_pend;
  logic [7:0] d_fc;

  // 5 slots x 3 stages, TAP_LAG=2
  logic       s_rst_n, s_en, s_sync;
  logic [2:0] s_slot;
  logic [1:0] s_stage;
  logic [5:0] s_tap_slot;
  logic [3:0] s_tap_stage;
  logic       s_fs, s_pend;
  logic [7:0] s_fc;

  opll_slot_sequencer u_a (
    .clk(clk), .reset_n(a_rst_n), .clkena(a_en), .sync_req(a_sync),
    .slot(a_slot), .stage(a_stage), .tap_slot(a_tap_slot), .tap_stage(a_tap_stage),
    .frame_start(a_fs), .frame_count(a_fc), .sync_pending(a_pend)
  );

  opll_slot_sequencer #(.DELAY(5)) u_d (
    .clk(clk), .reset_n(d_rst_n), .clkena(d_en), .sync_req(d_sync),
    .slot(d_slot), .stage(d_stage), .tap_slot(d_tap_slot), .tap_stage(d_tap_stage),
    .frame_start(d_fs), .frame_count(d_fc), .sync_pending(d_pend)
  );

  opll_slot_sequencer #(.NUM_SLOTS(5), .NUM_STAGES(3), .TAP_LAG(2), .NUM_TAPS(2)) u_s (
    .clk(clk), .reset_n(s_rst_n), .clkena(s_en), .sync_req(s_sync),
    .slot(s_slot), .stage(s_stage), .tap_slot(s_tap_slot), .tap_stage(s_tap_stage),
    .frame_start(s_fs), .frame_count(s_fc), .sync_pending(s_pend)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int a_pos();
    return int'(a_slot) * 4 + int'(a_stage);
  endfunction
  function automatic int a_tap(input int k);
    logic [4:0] sl;
    logic [1:0] st;
    sl = a_tap_slot[k*5 +: 5];
    st = a_tap_stage[k*2 +: 2];
    return int'(sl) * 4 + int'(st);
  endfunction
  function automatic int d_pos();
    return int'(d_slot) * 4 + int'(d_stage);
  endfunction
  function automatic int s_pos();
    return int'(s_slot) * 3 + int'(s_stage);
  endfunction
  function automatic int s_tap(input int k);
    logic [2:0] sl;
    logic [1:0] st;
    sl = s_tap_slot[k*3 +: 3];
    st = s_tap_stage[k*2 +: 2];
    return int'(sl) * 3 + int'(st);
  endfunction

  initial begin
    int ep;
    a_rst_n = 0; a_en = 0; a_sync = 0;
    d_rst_n = 0; d_en = 0; d_sync = 0;
    s_rst_n = 0; s_en = 0; s_sync = 0;
    #12;
    // Reset values
    check("a_rst_slot", int'(a_slot), 17);
    check("a_rst_stage", int'(a_stage), 3);
    check("a_rst_tap0", a_tap(0), 70);
    check("a_rst_tap1", a_tap(1), 69);
    check("a_rst_fc", int'(a_fc), 0);
    check("a_rst_pend", int'(a_pend), 0);
    check("a_rst_fs", int'(a_fs), 0);
    check("d_rst_slot", int'(d_slot), 16);
    check("d_rst_stage", int'(d_stage), 2);
    check("s_rst_pos", s_pos(), 14);
    check("s_rst_tap0", s_tap(0), 12);
    check("s_rst_tap1", s_tap(1), 10);
    a_rst_n = 1; d_rst_n = 1; s_rst_n = 1;

    // Default: first edge wraps to 0
    a_en = 1;
    tick();
    check("a_first_pos", a_pos(), 0);
    check("a_first_fs", int'(a_fs), 1);
    check("a_first_fc", int'(a_fc), 1);
    check("a_first_tap0", a_tap(0), 71);
    check("a_first_tap1", a_tap(1), 70);
    repeat (72) tick();
    check("a_frame2_pos", a_pos(), 0);
    check("a_frame2_fc", int'(a_fc), 2);
    repeat (40) tick();
    check("a_p40_pos", a_pos(), 40);
    check("a_p40_fs", int'(a_fs), 0);

    // Sync request while frozen
    a_en = 0; a_sync = 1;
    tick();
    a_sync = 0;
    check("a_sync_pend", int'(a_pend), 1);
    check("a_sync_frozen", a_pos(), 40);
    tick();
    check("a_sync_hold_pos", a_pos(), 40);
    check("a_sync_hold_pend", int'(a_pend), 1);
    a_en = 1;
    tick();
    check("a_sync_load_pos", a_pos(), 0);
    check("a_sync_load_pend", int'(a_pend), 0);
    check("a_sync_load_fc", int'(a_fc), 2);
    check("a_sync_load_tap0", a_tap(0), 71);
    check("a_sync_load_tap1", a_tap(1), 70);

    // Sync at p=71 suppresses frame increment
    repeat (71) tick();
    check("a_p71_pos", a_pos(), 71);
    a_sync = 1;
    tick();
    a_sync = 0;
    check("a_syncwrap_pos", a_pos(), 0);
    check("a_syncwrap_fc", int'(a_fc), 2);
    check("a_syncwrap_pend", int'(a_pend), 0);
    repeat (71) tick();
    check("a_p71b_pos", a_pos(), 71);
    tick();
    check("a_natwrap_pos", a_pos(), 0);
    check("a_natwrap_fc", int'(a_fc), 3);

    // Asynchronous reset mid-slot with a pending sync
    repeat (5) tick();
    check("a_p5_pos", a_pos(), 5);
    a_en = 0; a_sync = 1;
    tick();
    a_sync = 0;
    check("a_p5_pend", int'(a_pend), 1);
    #3 a_rst_n = 0;
    #1;
    check("a_arst_pos", a_pos(), 71);
    check("a_arst_pend", int'(a_pend), 0);
    check("a_arst_fc", int'(a_fc), 0);
    check("a_arst_tap0", a_tap(0), 70);
    #1 a_rst_n = 1;
    tick();
    check("a_after_rst_pend", int'(a_pend), 0);
    check("a_after_rst_pos", a_pos(), 71);

    // DELAY=5, clkena high one cycle in three
    for (int i = 1; i <= 6; i++) begin
      d_en = 1;
      tick();
      check("d_step_pos", d_pos(), (66 + i) % 72);
      d_en = 0;
      tick();
      tick();
      check("d_frozen_pos", d_pos(), (66 + i) % 72);
      check("d_frozen_fs", int'(d_fs), (i == 6) ? 1 : 0);
    end
    check("d_wrap_fc", int'(d_fc), 1);

    // Small config: 3-frame sweep with tap lag checks
    s_en = 1;
    tick();
    ep = 0;
    check("s_first_fc", int'(s_fc), 1);
    for (int i = 0; i < 45; i++) begin
      check("s_stage", int'(s_stage), ep % 3);
      check("s_slot", int'(s_slot), ep / 3);
      check("s_tap0", s_tap(0), (ep + 13) % 15);
      check("s_tap1", s_tap(1), (ep + 11) % 15);
      check("s_fs", int'(s_fs), (ep == 0) ? 1 : 0);
      tick();
      ep = (ep + 1) % 15;
    end
    check("s_sweep_pos", s_pos(), 0);
    check("s_sweep_fc", int'(s_fc), 4);

    // Frame counter 255 -> 0
    repeat (251 * 15) tick();
    check("s_fc255", int'(s_fc), 255);
    check("s_fc255_pos", s_pos(), 0);
    repeat (15) tick();
    check("s_fc_wrap", int'(s_fc), 0);
    check("s_fc_wrap_fs", int'(s_fs), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
